// File: rtl/gpio_irq_ctrl.sv
// Switch-bank conditioner: per-input sync + debounce, edge-to-pending latch,
// registered interrupt and a small acknowledged register port.

module gpio_irq_lane #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q, stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd      = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            upd      = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Edge direction is the value being loaded into stable on the update event.
    assign stable_o = stable_q;
    assign rise_o   = upd &  sync2_q;
    assign fall_o   = upd & ~sync2_q;
endmodule

module gpio_irq_ctrl #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [1:0]   addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         ack,
    output logic [N-1:0] sw_stable,
    output logic         irq
);
    logic [N-1:0] stable, rise, fall;
    logic [N-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [N-1:0] pend_q, pend_d, rdata_q, rdata_d;
    logic [N-1:0] set_v, clr_v;
    logic         ack_q, irq_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        gpio_irq_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .sw_i     (sw[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    always_comb begin
        set_v     = (rise & rise_en_q) | (fall & fall_en_q);
        clr_v     = (wr_en && addr == 2'd3) ? wdata : '0;
        // Set wins over a same-edge clear so no event is lost.
        pend_d    = (pend_q & ~clr_v) | set_v;
        rise_en_d = (wr_en && addr == 2'd1) ? wdata : rise_en_q;
        fall_en_d = (wr_en && addr == 2'd2) ? wdata : fall_en_q;
        rdata_d   = rdata_q;
        if (rd_en && !wr_en) begin
            case (addr)
                2'd0:    rdata_d = stable;
                2'd1:    rdata_d = rise_en_q;
                2'd2:    rdata_d = fall_en_q;
                default: rdata_d = pend_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            rdata_q   <= rdata_d;
            ack_q     <= wr_en | rd_en;
            irq_q     <= |pend_q;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign sw_stable = stable;
    assign irq       = irq_q;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scenario bench for gpio_irq_ctrl with N=4, DB_CYCLES=4; read results are
// queued as expectations when issued and popped when the ack arrives.

module tb_gpio_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = 4'hF;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [3:0] wdata = 4'h0;
    logic [3:0] rdata, sw_stable;
    logic       ack, irq;

    int checks = 0;
    int errors = 0;
    logic [3:0] q[$];
    logic [3:0] rd, exp_v;
    logic       ak;

    gpio_irq_ctrl #(.N(4), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .sw_stable(sw_stable), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [1:0] a,
                       input logic [3:0] d, output logic [3:0] rd_o, output logic ak_o);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        @(posedge clk);
        #1;
        rd_o = rdata; ak_o = ack;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            wr_en = i[0]; rd_en = ~i[0]; addr = i[1:0]; wdata = 4'hF;
            tick(1);
            checks++;
            if ({rdata, ack, irq, sw_stable} !== 10'h0) begin
                errors++;
                $display("FAIL reset_hold: rdata=%h ack=%b irq=%b sw_stable=%h required all 0",
                         rdata, ack, irq, sw_stable);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b1;
        tick(5);
        checks++;
        if (sw_stable !== 4'h0) begin
            errors++; $display("FAIL reset_edge5: sw_stable=%h required 0", sw_stable);
        end
        tick(1);
        checks++;
        if (sw_stable !== 4'hF) begin
            errors++; $display("FAIL reset_edge6: sw_stable=%h required F", sw_stable);
        end
        tick(3);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_noirq: irq=%b required 0", irq);
        end
        sw = 4'h0;
        tick(8);
        checks++;
        if (sw_stable !== 4'h0) begin
            errors++; $display("FAIL reset_settle: sw_stable=%h required 0", sw_stable);
        end
    endtask

    task automatic test_debounce;
        bus(1, 0, 2'd1, 4'h1, rd, ak);
        sw = 4'h1;
        tick(3);
        sw = 4'h0;
        tick(8);
        checks++;
        if (sw_stable[0] !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL glitch: sw_stable0=%b irq=%b required 0 0", sw_stable[0], irq);
        end
        sw = 4'h1;
        tick(5);
        checks++;
        if (sw_stable[0] !== 1'b0) begin
            errors++; $display("FAIL db_edge5: sw_stable0=%b required 0", sw_stable[0]);
        end
        tick(1);
        checks++;
        if (sw_stable[0] !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL db_edge6: sw_stable0=%b irq=%b required 1 0", sw_stable[0], irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL db_edge7: irq=%b required 1", irq);
        end
        q.push_back(4'h1);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL db_pending: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        bus(1, 0, 2'd3, 4'h1, rd, ak);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL w1c_irq_k: irq=%b required 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL w1c_irq_k1: irq=%b required 0", irq);
        end
        sw = 4'h0;
        tick(8);
        q.push_back(4'h0);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL db_nofall: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
    endtask

    task automatic test_edge_sel;
        bus(1, 0, 2'd1, 4'h2, rd, ak);
        bus(1, 0, 2'd2, 4'h4, rd, ak);
        sw = 4'hE;
        tick(8);
        q.push_back(4'h2);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL sel_rise: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        sw = 4'h0;
        tick(8);
        q.push_back(4'h6);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd, irq} !== {1'b1, exp_v, 1'b1}) begin
            errors++; $display("FAIL sel_fall: ack=%b rdata=%h irq=%b required 1 %h 1", ak, rd, irq, exp_v);
        end
        bus(1, 0, 2'd3, 4'hF, rd, ak);
        tick(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL sel_clear: irq=%b required 0", irq);
        end
    endtask

    task automatic test_w1c_collision;
        bus(1, 0, 2'd1, 4'h3, rd, ak);
        bus(1, 0, 2'd2, 4'h2, rd, ak);
        sw = 4'h3;
        tick(8);
        q.push_back(4'h3);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL col_pend3: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        bus(1, 0, 2'd3, 4'h1, rd, ak);
        q.push_back(4'h2);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL col_w1c: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        // sw[1] falls; its update event lands on edge 6, together with the clear.
        sw = 4'h1;
        tick(5);
        bus(1, 0, 2'd3, 4'h2, rd, ak);
        tick(1);
        q.push_back(4'h2);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd, irq} !== {1'b1, exp_v, 1'b1}) begin
            errors++; $display("FAIL col_setwins: ack=%b rdata=%h irq=%b required 1 %h 1", ak, rd, irq, exp_v);
        end
        bus(1, 0, 2'd1, 4'h0, rd, ak);
        bus(1, 0, 2'd2, 4'h0, rd, ak);
        sw = 4'h0;
        tick(8);
        bus(1, 0, 2'd3, 4'hF, rd, ak);
        tick(2);
    endtask

    task automatic test_back_to_back;
        bus(1, 0, 2'd1, 4'h5, rd, ak);
        q.push_back(4'h5);
        bus(0, 1, 2'd1, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL bus_rd5: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        bus(1, 1, 2'd1, 4'hA, rd, ak);
        checks++;
        if ({ak, rd} !== 5'h15) begin
            errors++; $display("FAIL bus_wrrd: ack=%b rdata=%h required 1 5", ak, rd);
        end
        tick(1);
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL bus_oneack: ack=%b required 0", ack);
        end
        q.push_back(4'hA);
        bus(0, 1, 2'd1, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL bus_rdA: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        sw = 4'h4;
        tick(8);
        bus(1, 0, 2'd0, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b1) begin
            errors++; $display("FAIL bus_state_ack: ack=%b required 1", ak);
        end
        q.push_back(4'h4);
        bus(0, 1, 2'd0, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL bus_state: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        bus(1, 0, 2'd2, 4'h3, rd, ak);
        q.push_back(4'h3);
        bus(0, 1, 2'd2, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL bus_b2b: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        bus(1, 0, 2'd2, 4'h0, rd, ak);
    endtask

    task automatic test_reset_mid;
        bus(1, 0, 2'd1, 4'h8, rd, ak);
        sw = 4'hC;
        tick(8);
        q.push_back(4'h8);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL mid_pend8: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        sw = 4'h4;
        tick(3);
        checks++;
        if (irq !== 1'b1 || sw_stable !== 4'hC) begin
            errors++; $display("FAIL mid_pre: irq=%b sw_stable=%h required 1 C", irq, sw_stable);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rdata, ack, irq, sw_stable} !== 10'h0) begin
            errors++; $display("FAIL mid_async: rdata=%h ack=%b irq=%b sw_stable=%h required all 0",
                               rdata, ack, irq, sw_stable);
        end
        #1 rst = 1'b1;
        tick(8);
        q.push_back(4'h0);
        bus(0, 1, 2'd3, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd} !== {1'b1, exp_v}) begin
            errors++; $display("FAIL mid_pend0: ack=%b rdata=%h required 1 %h", ak, rd, exp_v);
        end
        q.push_back(4'h0);
        bus(0, 1, 2'd1, 4'h0, rd, ak);
        exp_v = q.pop_front();
        checks++;
        if ({ak, rd, sw_stable} !== {1'b1, exp_v, 4'h4}) begin
            errors++; $display("FAIL mid_en0: ack=%b rdata=%h sw_stable=%h required 1 %h 4",
                               ak, rd, sw_stable, exp_v);
        end
    endtask

    initial begin
        tick(1);
        test_reset;
        test_debounce;
        test_edge_sel;
        test_w1c_collision;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
